// File: rtl/pim_buf_dma.sv
// Word-granular DMA copy from DMEM into the PIM buffer: one read, one write per word.
// Optional destination bounds check enabled by defining PIM_DMA_BOUND_CHK_EN.
module pim_buf_dma #(
    parameter int MEM_DEPTH      = 28672,
    parameter int MEM_ADDR_WIDTH = 15,
    parameter int LEN_WIDTH      = 13
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len,
    output logic [31:0]          o_src_addr,
    output logic                 o_src_read,
    input  logic [31:0]          i_src_rd_data,
    output logic [31:0]          o_buf_addr,
    output logic [31:0]          o_buf_wr_data,
    output logic [3:0]           o_buf_size,
    output logic                 o_buf_write,
    output logic                 o_buf_read,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [LEN_WIDTH-1:0] o_count
);

    // state  | meaning
    // S_IDLE | waiting for i_start
    // S_RD   | DMEM read strobe for the current word
    // S_WR   | PIM buffer write of the word read last cycle
    // S_DONE | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);
    localparam logic [31:0]          WORD_MSK = 32'hFFFF_FFFC;

    if (MEM_DEPTH > (1 << MEM_ADDR_WIDTH)) begin : g_cfg_check
        $error("pim_buf_dma: MEM_DEPTH does not fit in MEM_ADDR_WIDTH");
    end

    state_t               state;
    state_t               state_nxt;
    logic [31:0]          src_ptr;
    logic [31:0]          dst_ptr;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] count_inc;
    logic                 bound_bad;
    logic                 start_xfer;

`ifdef PIM_DMA_BOUND_CHK_EN
    logic [33:0] dst_end;
    assign dst_end   = {2'b00, i_dst_addr & WORD_MSK}
                     + {{(32-LEN_WIDTH){1'b0}}, i_len, 2'b00};
    assign bound_bad = (dst_end > 34'(MEM_DEPTH));
`else
    assign bound_bad = 1'b0;
`endif

    assign count_inc  = count + CNT_ONE;
    assign start_xfer = (state == S_IDLE) && i_start && !bound_bad && (i_len != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (bound_bad || (i_len == '0)) ? S_DONE : S_RD;
                end
            end
            S_RD:   state_nxt = i_abort ? S_IDLE : S_WR;
            S_WR: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = (count_inc == len_q) ? S_DONE : S_RD;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_src_read    = (state == S_RD);
        o_buf_write   = (state == S_WR);
        o_busy        = (state == S_RD) || (state == S_WR);
        o_done        = (state == S_DONE);
        o_src_addr    = src_ptr;
        o_buf_addr    = dst_ptr;
        o_buf_wr_data = i_src_rd_data;
        o_buf_size    = 4'b1111;
        o_buf_read    = 1'b0;
        o_count       = count;
    end

    // An aborted WR still strobes, but its word is not counted and pointers hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            len_q   <= '0;
            count   <= '0;
        end else if (start_xfer) begin
            src_ptr <= i_src_addr & WORD_MSK;
            dst_ptr <= i_dst_addr & WORD_MSK;
            len_q   <= i_len;
            count   <= '0;
        end else if ((state == S_WR) && !i_abort) begin
            src_ptr <= src_ptr + 32'd4;
            dst_ptr <= dst_ptr + 32'd4;
            count   <= count_inc;
        end
    end

`ifdef PIM_DMA_BOUND_CHK_EN
    logic err_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if ((state == S_IDLE) && i_start) begin
            err_q <= bound_bad;
        end
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
